// File: rtl/fp_mul_seq.sv
// Sequential binary64 multiplier: 53-cycle shift-add significand product,
// round-to-nearest-even, DAZ inputs and FTZ outputs, start/done handshake.
module fp_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] fp_a,
  input  logic [63:0] fp_b,
  output logic [63:0] fp_out,
  output logic        done,
  output logic        busy,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);
  typedef enum logic [2:0] {IDLE, PREPARE, MULT, NORMALIZE, ROUND, PACK, DONE} state_t;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  state_t             state_reg, state_next;
  logic [63:0]        a_reg, b_reg, result_reg;
  logic               sign_reg, special_reg;
  logic signed [12:0] exp_reg;
  logic [52:0]        acc_reg, mcand_reg, mplier_reg;
  logic [51:0]        frac_reg;
  logic [5:0]         cnt_reg;
  logic               g_reg, r_reg, s_reg;

  logic [10:0]  ea, eb;
  logic [51:0]  fa, fb;
  logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
  logic [53:0]  add_sum;
  logic [105:0] prod;
  logic         round_up;

  assign ea = a_reg[62:52];
  assign eb = b_reg[62:52];
  assign fa = a_reg[51:0];
  assign fb = b_reg[51:0];
  // Exponent field 0 covers both true zero and denormals (treated as zero).
  assign a_zero  = (ea == 11'd0);
  assign b_zero  = (eb == 11'd0);
  assign a_inf   = (ea == 11'h7FF) && (fa == 52'd0);
  assign b_inf   = (eb == 11'h7FF) && (fb == 52'd0);
  assign a_nan   = (ea == 11'h7FF) && (fa != 52'd0);
  assign b_nan   = (eb == 11'h7FF) && (fb != 52'd0);
  assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

  assign add_sum  = mplier_reg[0] ? ({1'b0, acc_reg} + {1'b0, mcand_reg}) : {1'b0, acc_reg};
  assign prod     = {acc_reg, mplier_reg};
  assign round_up = g_reg & (r_reg | s_reg | frac_reg[0]);
  assign busy     = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (start) state_next = PREPARE;
      PREPARE:   state_next = special ? PACK : MULT;
      MULT:      if (cnt_reg == 6'd1) state_next = NORMALIZE;
      NORMALIZE: state_next = ROUND;
      ROUND:     state_next = PACK;
      PACK:      state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      result_reg  <= '0;
      sign_reg    <= 1'b0;
      special_reg <= 1'b0;
      exp_reg     <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      frac_reg    <= '0;
      cnt_reg     <= '0;
      g_reg       <= 1'b0;
      r_reg       <= 1'b0;
      s_reg       <= 1'b0;
      fp_out      <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= fp_a;
            b_reg     <= fp_b;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
          end
        end
        PREPARE: begin
          sign_reg    <= a_reg[63] ^ b_reg[63];
          special_reg <= special;
          if (a_nan | b_nan) begin
            result_reg <= QNAN;
          end else if ((a_zero & b_inf) | (a_inf & b_zero)) begin
            result_reg <= QNAN;
            invalid    <= 1'b1;
          end else if (a_inf | b_inf) begin
            result_reg <= {a_reg[63] ^ b_reg[63], 11'h7FF, 52'd0};
          end else if (a_zero | b_zero) begin
            result_reg <= {a_reg[63] ^ b_reg[63], 63'd0};
          end else begin
            // Two biases removed at once: unbiased sum = ea + eb - 2046.
            exp_reg    <= {2'b00, ea} + {2'b00, eb} - 13'd2046;
            acc_reg    <= '0;
            mcand_reg  <= {1'b1, fa};
            mplier_reg <= {1'b1, fb};
            cnt_reg    <= 6'd53;
          end
        end
        MULT: begin
          acc_reg    <= add_sum[53:1];
          mplier_reg <= {add_sum[0], mplier_reg[52:1]};
          cnt_reg    <= cnt_reg - 6'd1;
        end
        NORMALIZE: begin
          if (prod[105]) begin
            frac_reg <= prod[104:53];
            g_reg    <= prod[52];
            r_reg    <= prod[51];
            s_reg    <= |prod[50:0];
            exp_reg  <= exp_reg + 13'sd1;
          end else begin
            frac_reg <= prod[103:52];
            g_reg    <= prod[51];
            r_reg    <= prod[50];
            s_reg    <= |prod[49:0];
          end
        end
        ROUND: begin
          // The hidden bit is always set, so a carry out happens only from an all-ones fraction.
          if (round_up) begin
            if (&frac_reg) begin
              frac_reg <= '0;
              exp_reg  <= exp_reg + 13'sd1;
            end else begin
              frac_reg <= frac_reg + 52'd1;
            end
          end
        end
        PACK: begin
          if (!special_reg) begin
            if (exp_reg > 13'sd1023) begin
              result_reg <= {sign_reg, 11'h7FF, 52'd0};
              overflow   <= 1'b1;
            end else if (exp_reg < -13'sd1022) begin
              result_reg <= {sign_reg, 63'd0};
              underflow  <= 1'b1;
            end else begin
              result_reg <= {sign_reg, 11'(exp_reg + 13'sd1023), frac_reg};
            end
          end
        end
        DONE: begin
          fp_out <= result_reg;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
